id_ex_stage: RTL and testbench

- Downstream neighbour of the main decoder; sits at the ID/EX boundary of the 5-stage MIPS pipeline.
- Registers the decoder control bits, register-file read data, extended immediate and register specifiers for EX.
- Detects load-use hazards, freezes PC and IF/ID, and inserts a bubble.
- Honours a hold request from EX/MEM and keeps a saturating count of hazard bubbles.

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/hazard_detect.sv | 25 ++
 rtl/id_ex_stage.sv | 152 +++++++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: opcodes, ALU classes,
// field widths and the ID/EX control bundle.
package mips_pkg;

  localparam int REG_W   = 5;
  localparam int FUNCT_W = 6;
  localparam int OPC_W   = 6;
  localparam int IMM_W   = 16;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OPC_W-1:0] OP_ADDIU = 6'b001001;
  localparam logic [OPC_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_OR    = 2'b11;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_w;
    logic       alu_src;
    logic       mem_w;
    logic       mem_to_reg;
    logic       mem_read;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    ctrl_t              ctrl;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   dst;
    logic [FUNCT_W-1:0] funct;
  } id_ex_t;

  // rt is read as a source only by R-type and sw
  function automatic logic uses_rt(input logic [OPC_W-1:0] op);
    return (op == OP_RTYPE) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a lw in EX whose destination
// is read by the instruction currently in ID.
module hazard_detect
  import mips_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             id_valid,
  input  logic [OPC_W-1:0] id_opcode,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  output logic             hazard
);

  logic ex_load;
  logic rs_hit;
  logic rt_hit;

  assign ex_load = ex_valid & ex_mem_read & (ex_rt != '0);
  assign rs_hit  = (ex_rt == id_rs);
  assign rt_hit  = uses_rt(id_opcode) & (ex_rt == id_rt);
  assign hazard  = ex_load & id_valid & (rs_hit | rt_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, hold
// and a saturating bubble counter.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic              id_reg_dst,
  input  logic              id_reg_w,
  input  logic              id_alu_src,
  input  logic              id_mem_w,
  input  logic              id_mem_to_reg,
  input  logic              id_mem_read,
  input  logic [1:0]        id_alu_op,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              hold,
  output logic              ex_valid,
  output logic              ex_reg_dst,
  output logic              ex_reg_w,
  output logic              ex_alu_src,
  output logic              ex_mem_w,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_read,
  output logic [1:0]        ex_alu_op,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_dst,
  output logic [5:0]        ex_funct,
  output logic              pc_write,
  output logic              ifid_write,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [OPC_W-1:0]   opc;
  logic [REG_W-1:0]   f_rs;
  logic [REG_W-1:0]   f_rt;
  logic [REG_W-1:0]   f_rd;
  logic [IMM_W-1:0]   f_imm;
  ctrl_t              id_ctrl;
  id_ex_t             id_nxt;
  id_ex_t             ex_q;
  logic               ex_valid_q;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  rs_data_q;
  logic [DATA_W-1:0]  rt_data_q;
  logic [DATA_W-1:0]  imm_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               hazard;
  logic               stall;

  assign opc   = id_instr[31:26];
  assign f_rs  = id_instr[25:21];
  assign f_rt  = id_instr[20:16];
  assign f_rd  = id_instr[15:11];
  assign f_imm = id_instr[15:0];

  assign id_ctrl = '{
    reg_dst:    id_reg_dst,
    reg_w:      id_reg_w,
    alu_src:    id_alu_src,
    mem_w:      id_mem_w,
    mem_to_reg: id_mem_to_reg,
    mem_read:   id_mem_read,
    alu_op:     id_alu_op
  };

  hazard_detect u_hazard (
    .ex_valid    (ex_valid_q),
    .ex_mem_read (ex_q.ctrl.mem_read),
    .ex_rt       (ex_q.rt),
    .id_valid    (id_valid),
    .id_opcode   (opc),
    .id_rs       (f_rs),
    .id_rt       (f_rt),
    .hazard      (hazard)
  );

  assign stall      = hold | hazard;
  assign pc_write   = ~rst_n | ~stall;
  assign ifid_write = ~rst_n | ~stall;

  always_comb begin
    imm_ext = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};
    unique case (1'b1)
      (opc == OP_ORI): imm_ext = {{(DATA_W-IMM_W){1'b0}}, f_imm};
      default:         imm_ext = {{(DATA_W-IMM_W){f_imm[IMM_W-1]}}, f_imm};
    endcase
  end

  // A bubble or an empty slot only needs its controls cleared
  always_comb begin
    id_nxt       = '0;
    id_nxt.rs    = f_rs;
    id_nxt.rt    = f_rt;
    id_nxt.dst   = id_reg_dst ? f_rd : f_rt;
    id_nxt.funct = id_instr[5:0];
    id_nxt.ctrl  = (id_valid & ~hazard) ? id_ctrl : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
    end else if (!hold) begin
      ex_q       <= id_nxt;
      ex_valid_q <= id_valid & ~hazard;
      rs_data_q  <= id_rs_data;
      rt_data_q  <= id_rt_data;
      imm_q      <= imm_ext;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!hold && hazard && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_reg_dst    = ex_q.ctrl.reg_dst;
  assign ex_reg_w      = ex_q.ctrl.reg_w;
  assign ex_alu_src    = ex_q.ctrl.alu_src;
  assign ex_mem_w      = ex_q.ctrl.mem_w;
  assign ex_mem_to_reg = ex_q.ctrl.mem_to_reg;
  assign ex_mem_read   = ex_q.ctrl.mem_read;
  assign ex_alu_op     = ex_q.ctrl.alu_op;
  assign ex_rs_data    = rs_data_q;
  assign ex_rt_data    = rt_data_q;
  assign ex_imm        = imm_q;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_dst        = ex_q.dst;
  assign ex_funct      = ex_q.funct;
  assign bubble_cnt    = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push
// expected EX state; a monitor pops and compares each cycle.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr;
  logic        id_reg_dst, id_reg_w, id_alu_src;
  logic        id_mem_w, id_mem_to_reg, id_mem_read;
  logic [1:0]  id_alu_op;
  logic [31:0] id_rs_data, id_rt_data;
  logic        hold;
  logic        ex_valid;
  logic        ex_reg_dst, ex_reg_w, ex_alu_src;
  logic        ex_mem_w, ex_mem_to_reg, ex_mem_read;
  logic [1:0]  ex_alu_op;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [5:0]  ex_funct;
  logic        pc_write, ifid_write;
  logic [3:0]  bubble_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic        pcw;
    logic        v;
    logic [7:0]  c;
    logic [4:0]  dst;
    logic [4:0]  rs;
    logic [31:0] imm;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];

  // ctrl byte: reg_dst reg_w alu_src mem_w mem_to_reg mem_read alu_op
  localparam logic [7:0] C_ADDIU = 8'h60;
  localparam logic [7:0] C_ORI   = 8'h63;
  localparam logic [7:0] C_LW    = 8'h6C;
  localparam logic [7:0] C_ADD   = 8'hC2;
  localparam logic [7:0] C_SW    = 8'h30;

  localparam logic [31:0] I_ADDIU  = 32'h2528FFFC;
  localparam logic [31:0] I_ORI    = 32'h35288001;
  localparam logic [31:0] I_LW5    = 32'h8C450000;
  localparam logic [31:0] I_ADD    = 32'h00A73020;
  localparam logic [31:0] I_ADDIU5 = 32'h24650001;
  localparam logic [31:0] I_LW0    = 32'h8C400000;
  localparam logic [31:0] I_ADD0   = 32'h00003020;
  localparam logic [31:0] I_SW     = 32'hAC450004;

  id_ex_stage #(.DATA_W(32), .CNT_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .id_valid      (id_valid),
    .id_instr      (id_instr),
    .id_reg_dst    (id_reg_dst),
    .id_reg_w      (id_reg_w),
    .id_alu_src    (id_alu_src),
    .id_mem_w      (id_mem_w),
    .id_mem_to_reg (id_mem_to_reg),
    .id_mem_read   (id_mem_read),
    .id_alu_op     (id_alu_op),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .hold          (hold),
    .ex_valid      (ex_valid),
    .ex_reg_dst    (ex_reg_dst),
    .ex_reg_w      (ex_reg_w),
    .ex_alu_src    (ex_alu_src),
    .ex_mem_w      (ex_mem_w),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_mem_read   (ex_mem_read),
    .ex_alu_op     (ex_alu_op),
    .ex_rs_data    (ex_rs_data),
    .ex_rt_data    (ex_rt_data),
    .ex_imm        (ex_imm),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_dst        (ex_dst),
    .ex_funct      (ex_funct),
    .pc_write      (pc_write),
    .ifid_write    (ifid_write),
    .bubble_cnt    (bubble_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ex_ctrl();
    return {ex_reg_dst, ex_reg_w, ex_alu_src, ex_mem_w,
            ex_mem_to_reg, ex_mem_read, ex_alu_op};
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ins, input logic [7:0] c,
                       input logic v, input logic h);
    id_instr = ins;
    {id_reg_dst, id_reg_w, id_alu_src, id_mem_w,
     id_mem_to_reg, id_mem_read, id_alu_op} = c;
    id_valid   = v;
    hold       = h;
    id_rs_data = ins;
    id_rt_data = ~ins;
  endtask

  task automatic step(input string tag, input logic [31:0] ins,
                      input logic [7:0] c, input logic v,
                      input logic h, input logic e_pcw,
                      input logic e_v, input logic [7:0] e_c,
                      input logic [4:0] e_dst, input logic [4:0] e_rs,
                      input logic [31:0] e_imm, input logic [3:0] e_cnt);
    exp_t e;
    @(posedge clk);
    #2;
    drive(ins, c, v, h);
    e = '{tag: tag, pcw: e_pcw, v: e_v, c: e_c, dst: e_dst,
          rs: e_rs, imm: e_imm, cnt: e_cnt};
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".pc_write"}, 32'(pc_write), 32'(e.pcw));
        chk({e.tag, ".ifid_write"}, 32'(ifid_write), 32'(e.pcw));
        @(posedge clk);
        #1;
        chk({e.tag, ".ex_valid"}, 32'(ex_valid), 32'(e.v));
        chk({e.tag, ".ctrl"}, 32'(ex_ctrl()), 32'(e.c));
        chk({e.tag, ".bubble_cnt"}, 32'(bubble_cnt), 32'(e.cnt));
        if (e.v) begin
          chk({e.tag, ".ex_dst"}, 32'(ex_dst), 32'(e.dst));
          chk({e.tag, ".ex_rs"}, 32'(ex_rs), 32'(e.rs));
          chk({e.tag, ".ex_imm"}, ex_imm, e.imm);
        end
      end
    end
  end

  initial begin : stim
    logic [3:0] cnt;
    int n;
    rst_n = 1'b0;
    drive(32'h0, 8'h00, 1'b0, 1'b1);
    #3;
    chk("rst.ex_valid", 32'(ex_valid), 32'd0);
    chk("rst.ctrl", 32'(ex_ctrl()), 32'd0);
    chk("rst.bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("rst.ex_imm", ex_imm, 32'd0);
    chk("rst.pc_write", 32'(pc_write), 32'd1);
    chk("rst.ifid_write", 32'(ifid_write), 32'd1);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    step("addiu", I_ADDIU, C_ADDIU, 1, 0, 1, 1, C_ADDIU, 8, 9, 32'hFFFFFFFC, 0);
    step("ori", I_ORI, C_ORI, 1, 0, 1, 1, C_ORI, 8, 9, 32'h00008001, 0);
    step("lw5", I_LW5, C_LW, 1, 0, 1, 1, C_LW, 5, 2, 32'h0, 0);
    step("use.stall", I_ADD, C_ADD, 1, 0, 0, 0, 8'h00, 0, 0, 32'h0, 1);
    step("use.go", I_ADD, C_ADD, 1, 0, 1, 1, C_ADD, 6, 5, 32'h00003020, 1);
    step("lw5b", I_LW5, C_LW, 1, 0, 1, 1, C_LW, 5, 2, 32'h0, 1);
    step("rt.nosrc", I_ADDIU5, C_ADDIU, 1, 0, 1, 1, C_ADDIU, 5, 3, 32'h1, 1);
    step("lw0", I_LW0, C_LW, 1, 0, 1, 1, C_LW, 0, 2, 32'h0, 1);
    step("use0", I_ADD0, C_ADD, 1, 0, 1, 1, C_ADD, 6, 0, 32'h00003020, 1);
    step("lw5c", I_LW5, C_LW, 1, 0, 1, 1, C_LW, 5, 2, 32'h0, 1);
    for (int i = 0; i < 3; i++)
      step("hold", I_SW, C_SW, 1, 1, 0, 1, C_LW, 5, 2, 32'h0, 1);
    step("sw.stall", I_SW, C_SW, 1, 0, 0, 0, 8'h00, 0, 0, 32'h0, 2);
    step("sw.go", I_SW, C_SW, 1, 0, 1, 1, C_SW, 5, 2, 32'h4, 2);
    step("invalid", I_ADDIU, C_ADDIU, 0, 0, 1, 0, 8'h00, 0, 0, 32'h0, 2);

    cnt = 4'd2;
    for (int i = 0; i < 16; i++) begin
      step("sat.lw", I_LW5, C_LW, 1, 0, 1, 1, C_LW, 5, 2, 32'h0, cnt);
      if (cnt != 4'hF) cnt = cnt + 4'd1;
      step("sat.use", I_ADD, C_ADD, 1, 0, 0, 0, 8'h00, 0, 0, 32'h0, cnt);
    end

    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    chk("drain.queue", 32'(q.size()), 32'd0);
    repeat (2) @(posedge clk);

    @(posedge clk);
    #2;
    drive(I_LW5, C_LW, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    drive(I_ADD, C_ADD, 1'b1, 1'b0);
    #1;
    chk("mid.pre_pc_write", 32'(pc_write), 32'd0);
    chk("mid.pre_ex_valid", 32'(ex_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid.ex_valid", 32'(ex_valid), 32'd0);
    chk("mid.ctrl", 32'(ex_ctrl()), 32'd0);
    chk("mid.bubble_cnt", 32'(bubble_cnt), 32'd0);
    chk("mid.ex_dst", 32'(ex_dst), 32'd0);
    chk("mid.pc_write", 32'(pc_write), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(32'h0, 8'h00, 1'b0, 1'b0);
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
